rail_recovery: RTL and testbench

- Consumes the two-bit railed flag from the output limiter and actively walks the loop back off the rail.
- Waits for a persistent rail (programmable dwell), pulses an integrator clear, ramps a signed offset away from the railed side, then waits a programmable settle time before re-arming.
- offset_out is summed into the servo output ahead of the limiter. hold_out freezes the integrator while recovery is in progress.

---
 rtl/rail_recovery_if.sv | 28 ++
 rtl/rail_recovery.sv | 154 +++++++++++++++
 tb/tb_rail_recovery.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rail_recovery_if.sv
// Bus bundle for the rail recovery controller: limiter flag and tuning inputs,
// correction/control outputs.
interface rail_recovery_if #(
  parameter int unsigned SIGNAL_SIZE = 16,
  parameter int unsigned COUNT_SIZE  = 16
);
  logic                   enable_in;
  logic [1:0]             railed_in;
  logic [COUNT_SIZE-1:0]  dwell_in;
  logic [COUNT_SIZE-1:0]  settle_in;
  logic [SIGNAL_SIZE-1:0] step_in;
  logic [SIGNAL_SIZE-1:0] offset_out;
  logic                   clear_out;
  logic                   hold_out;
  logic                   fault_out;
  logic [2:0]             state_out;
  logic [15:0]            relock_count_out;

  modport slave (
    input  enable_in, railed_in, dwell_in, settle_in, step_in,
    output offset_out, clear_out, hold_out, fault_out, state_out, relock_count_out
  );

  modport master (
    output enable_in, railed_in, dwell_in, settle_in, step_in,
    input  offset_out, clear_out, hold_out, fault_out, state_out, relock_count_out
  );
endinterface

// File: rtl/rail_recovery.sv
// Rail recovery controller: on a persistent limiter rail, clears the integrator
// and ramps a saturating offset away from the rail, then settles before re-arming.
module rail_recovery #(
  parameter int unsigned SIGNAL_SIZE = 16,
  parameter int unsigned COUNT_SIZE  = 16
) (
  input logic            clk_in,
  input logic            rst_in,
  rail_recovery_if.slave bus
);
  localparam int unsigned SW  = SIGNAL_SIZE;
  localparam int unsigned CW  = COUNT_SIZE;
  localparam int unsigned CW1 = COUNT_SIZE + 1;
  localparam int unsigned EW  = SIGNAL_SIZE + 2;
  localparam logic [SW-1:0]        POS_LIM = {1'b0, {(SW-1){1'b1}}};
  localparam logic [SW-1:0]        NEG_LIM = {1'b1, {(SW-1){1'b0}}};
  localparam logic signed [EW-1:0] POS_EXT = {2'b00, POS_LIM};
  localparam logic signed [EW-1:0] NEG_EXT = {2'b11, NEG_LIM};

  typedef enum logic [2:0] {
    ST_MONITOR = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_RAMP    = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_dir, w_dir_nxt;
  logic [SW-1:0] r_offset, w_offset_nxt;
  logic [15:0]   r_relock, w_relock_nxt;
  logic          r_clear, w_clear_nxt;
  logic          r_hold, w_hold_nxt;
  logic          r_fault, w_fault_nxt;

  logic                 w_railed;
  logic                 w_rail_hi;
  logic [CW-1:0]        w_dwell_n;
  logic [CW-1:0]        w_settle_n;
  logic [CW:0]          w_cnt_inc;
  logic                 w_dwell_hit;
  logic                 w_settle_hit;
  logic [15:0]          w_relock_inc;
  logic signed [EW-1:0] w_off_ext;
  logic signed [EW-1:0] w_step_ext;
  logic signed [EW-1:0] w_sum;
  logic [SW-1:0]        w_stepped;
  logic                 w_at_lim;

  assign w_railed     = (bus.railed_in == 2'b10) || (bus.railed_in == 2'b01);
  assign w_rail_hi    = (bus.railed_in == 2'b10);
  assign w_dwell_n    = (bus.dwell_in == '0) ? CW'(1) : bus.dwell_in;
  assign w_settle_n   = (bus.settle_in == '0) ? CW'(1) : bus.settle_in;
  assign w_cnt_inc    = {1'b0, r_cnt} + CW1'(1);
  assign w_dwell_hit  = w_cnt_inc >= {1'b0, w_dwell_n};
  assign w_settle_hit = w_cnt_inc >= {1'b0, w_settle_n};
  assign w_relock_inc = (r_relock == 16'hFFFF) ? r_relock : r_relock + 16'd1;

  // Step direction follows the rail seen this cycle, so a flip re-latches immediately
  assign w_off_ext  = {{2{r_offset[SW-1]}}, r_offset};
  assign w_step_ext = {2'b00, bus.step_in};
  assign w_sum      = w_rail_hi ? (w_off_ext - w_step_ext) : (w_off_ext + w_step_ext);
  assign w_stepped  = (w_sum > POS_EXT) ? POS_LIM :
                      (w_sum < NEG_EXT) ? NEG_LIM : w_sum[SW-1:0];
  assign w_at_lim   = w_rail_hi ? (r_offset == NEG_LIM) : (r_offset == POS_LIM);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state  <= ST_MONITOR;
      r_cnt    <= '0;
      r_dir    <= 1'b0;
      r_offset <= '0;
      r_relock <= '0;
      r_clear  <= 1'b0;
      r_hold   <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_dir    <= w_dir_nxt;
      r_offset <= w_offset_nxt;
      r_relock <= w_relock_nxt;
      r_clear  <= w_clear_nxt;
      r_hold   <= w_hold_nxt;
      r_fault  <= w_fault_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_dir_nxt    = r_dir;
    w_offset_nxt = r_offset;
    w_relock_nxt = r_relock;
    if (!bus.enable_in) begin
      w_state_nxt  = ST_MONITOR;
      w_cnt_nxt    = '0;
      w_offset_nxt = '0;
    end else begin
      unique case (r_state)
        ST_MONITOR: begin
          if (!w_railed) begin
            w_cnt_nxt = '0;
          end else if (w_dwell_hit) begin
            w_state_nxt  = ST_CLEAR;
            w_dir_nxt    = w_rail_hi;
            w_relock_nxt = w_relock_inc;
            w_cnt_nxt    = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc[CW-1:0];
          end
        end
        ST_CLEAR: w_state_nxt = ST_RAMP;
        ST_RAMP: begin
          if (!w_railed) begin
            w_state_nxt = ST_SETTLE;
            w_cnt_nxt   = '0;
          end else begin
            w_dir_nxt = w_rail_hi;
            if (w_at_lim) w_state_nxt  = ST_FAULT;
            else          w_offset_nxt = w_stepped;
          end
        end
        ST_SETTLE: begin
          if (w_railed) begin
            w_state_nxt  = ST_CLEAR;
            w_dir_nxt    = w_rail_hi;
            w_relock_nxt = w_relock_inc;
            w_cnt_nxt    = '0;
          end else if (w_settle_hit) begin
            w_state_nxt = ST_MONITOR;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc[CW-1:0];
          end
        end
        ST_FAULT: w_state_nxt = ST_FAULT;
        default:  w_state_nxt = ST_MONITOR;
      endcase
    end
    w_clear_nxt = (w_state_nxt == ST_CLEAR);
    w_hold_nxt  = (w_state_nxt == ST_CLEAR) || (w_state_nxt == ST_RAMP) ||
                  (w_state_nxt == ST_FAULT);
    w_fault_nxt = (w_state_nxt == ST_FAULT);
  end

  assign bus.offset_out       = r_offset;
  assign bus.clear_out        = r_clear;
  assign bus.hold_out         = r_hold;
  assign bus.fault_out        = r_fault;
  assign bus.state_out        = 3'(r_state);
  assign bus.relock_count_out = r_relock;
endmodule

// File: tb/tb_rail_recovery.sv
// Directed bench for rail_recovery: each task drives a scenario cycle by cycle
// and compares {state, offset, clear, hold, fault} against hand-derived values.
module tb_rail_recovery;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int   total = 0;
  int   bad   = 0;

  rail_recovery_if #(.SIGNAL_SIZE(16), .COUNT_SIZE(16)) bus ();

  rail_recovery #(.SIGNAL_SIZE(16), .COUNT_SIZE(16)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (bus)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [21:0] pk(input logic [2:0] st, input int off,
                                     input logic c, input logic h, input logic f);
    return {st, 16'(off), c, h, f};
  endfunction

  function automatic logic [21:0] obs();
    return {bus.state_out, bus.offset_out, bus.clear_out, bus.hold_out, bus.fault_out};
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    bus.enable_in = 1'b1;
    bus.railed_in = 2'b00;
    bus.dwell_in  = 16'd4;
    bus.settle_in = 16'd5;
    bus.step_in   = 16'd100;
    rst_in = 1'b1;
    step();
    step();
    total++;
    if (obs() !== pk(0, 0, 0, 0, 0)) begin
      bad++; $display("FAIL reset_outputs got=%h exp=%h", obs(), pk(0, 0, 0, 0, 0));
    end
    total++;
    if (bus.relock_count_out !== 16'd0) begin
      bad++; $display("FAIL reset_relock got=%0d exp=0", bus.relock_count_out);
    end
    rst_in = 1'b0;
  endtask

  task automatic test_dwell_short();
    bus.railed_in = 2'b10;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (obs() !== pk(0, 0, 0, 0, 0)) begin
        bad++; $display("FAIL dwell_short[%0d] got=%h exp=%h", i, obs(), pk(0, 0, 0, 0, 0));
      end
    end
    bus.railed_in = 2'b00;
    step();
    total++;
    if (obs() !== pk(0, 0, 0, 0, 0)) begin
      bad++; $display("FAIL dwell_short_release got=%h exp=%h", obs(), pk(0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_ramp_high();
    logic [21:0] e [8];
    e[0] = pk(0, 0, 0, 0, 0);
    e[1] = pk(0, 0, 0, 0, 0);
    e[2] = pk(0, 0, 0, 0, 0);
    e[3] = pk(1, 0, 1, 1, 0);
    e[4] = pk(2, 0, 0, 1, 0);
    e[5] = pk(2, -100, 0, 1, 0);
    e[6] = pk(2, -200, 0, 1, 0);
    e[7] = pk(2, -300, 0, 1, 0);
    bus.railed_in = 2'b10;
    for (int i = 0; i < 8; i++) begin
      step();
      total++;
      if (obs() !== e[i]) begin
        bad++; $display("FAIL ramp_high[%0d] got=%h exp=%h", i, obs(), e[i]);
      end
    end
    bus.railed_in = 2'b00;
    step();
    total++;
    if (obs() !== pk(3, -300, 0, 0, 0)) begin
      bad++; $display("FAIL ramp_release got=%h exp=%h", obs(), pk(3, -300, 0, 0, 0));
    end
    total++;
    if (bus.relock_count_out !== 16'd1) begin
      bad++; $display("FAIL relock_first got=%0d exp=1", bus.relock_count_out);
    end
  endtask

  task automatic test_settle_retry();
    logic [21:0] e [6];
    logic [1:0]  r [6];
    e[0] = pk(3, -300, 0, 0, 0); r[0] = 2'b00;
    e[1] = pk(3, -300, 0, 0, 0); r[1] = 2'b00;
    e[2] = pk(1, -300, 1, 1, 0); r[2] = 2'b01;
    e[3] = pk(2, -300, 0, 1, 0); r[3] = 2'b01;
    e[4] = pk(2, -200, 0, 1, 0); r[4] = 2'b01;
    e[5] = pk(2, -100, 0, 1, 0); r[5] = 2'b01;
    for (int i = 0; i < 6; i++) begin
      bus.railed_in = r[i];
      step();
      total++;
      if (obs() !== e[i]) begin
        bad++; $display("FAIL settle_retry[%0d] got=%h exp=%h", i, obs(), e[i]);
      end
      if (i == 2) begin
        total++;
        if (bus.relock_count_out !== 16'd2) begin
          bad++; $display("FAIL relock_retry got=%0d exp=2", bus.relock_count_out);
        end
      end
    end
    bus.railed_in = 2'b00;
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if (i < 5 && obs() !== pk(3, -100, 0, 0, 0)) begin
        bad++; $display("FAIL settle_wait[%0d] got=%h exp=%h", i, obs(), pk(3, -100, 0, 0, 0));
      end else if (i == 5 && obs() !== pk(0, -100, 0, 0, 0)) begin
        bad++; $display("FAIL settle_done got=%h exp=%h", obs(), pk(0, -100, 0, 0, 0));
      end
    end
  endtask

  task automatic test_reset_mid_ramp();
    bus.enable_in = 1'b0;
    step();
    total++;
    if (obs() !== pk(0, 0, 0, 0, 0)) begin
      bad++; $display("FAIL disable_clear got=%h exp=%h", obs(), pk(0, 0, 0, 0, 0));
    end
    bus.enable_in = 1'b1;
    bus.railed_in = 2'b10;
    for (int i = 0; i < 8; i++) step();
    total++;
    if (obs() !== pk(2, -300, 0, 1, 0)) begin
      bad++; $display("FAIL pre_reset_ramp got=%h exp=%h", obs(), pk(2, -300, 0, 1, 0));
    end
    rst_in = 1'b1;
    #2;
    total++;
    if (obs() !== pk(0, 0, 0, 0, 0) || bus.relock_count_out !== 16'd0) begin
      bad++; $display("FAIL async_reset got=%h relock=%0d exp=%h relock=0",
                      obs(), bus.relock_count_out, pk(0, 0, 0, 0, 0));
    end
    #1;
    rst_in = 1'b0;
    bus.railed_in = 2'b00;
  endtask

  task automatic test_saturation();
    logic [21:0] e [9];
    e[0] = pk(0, 0, 0, 0, 0);
    e[1] = pk(0, 0, 0, 0, 0);
    e[2] = pk(0, 0, 0, 0, 0);
    e[3] = pk(1, 0, 1, 1, 0);
    e[4] = pk(2, 0, 0, 1, 0);
    e[5] = pk(2, -16384, 0, 1, 0);
    e[6] = pk(2, -32768, 0, 1, 0);
    e[7] = pk(4, -32768, 0, 1, 1);
    e[8] = pk(4, -32768, 0, 1, 1);
    bus.step_in   = 16'h4000;
    bus.railed_in = 2'b10;
    for (int i = 0; i < 9; i++) begin
      step();
      total++;
      if (obs() !== e[i]) begin
        bad++; $display("FAIL saturation[%0d] got=%h exp=%h", i, obs(), e[i]);
      end
    end
    bus.enable_in = 1'b0;
    step();
    total++;
    if (obs() !== pk(0, 0, 0, 0, 0) || bus.relock_count_out !== 16'd1) begin
      bad++; $display("FAIL fault_exit got=%h relock=%0d exp=%h relock=1",
                      obs(), bus.relock_count_out, pk(0, 0, 0, 0, 0));
    end
    bus.enable_in = 1'b1;
    bus.railed_in = 2'b00;
    bus.step_in   = 16'd100;
  endtask

  task automatic test_dir_flip();
    logic [21:0] e [8];
    logic [1:0]  r [8];
    e[0] = pk(0, 0, 0, 0, 0);    r[0] = 2'b10;
    e[1] = pk(0, 0, 0, 0, 0);    r[1] = 2'b10;
    e[2] = pk(0, 0, 0, 0, 0);    r[2] = 2'b10;
    e[3] = pk(1, 0, 1, 1, 0);    r[3] = 2'b10;
    e[4] = pk(2, 0, 0, 1, 0);    r[4] = 2'b10;
    e[5] = pk(2, -100, 0, 1, 0); r[5] = 2'b10;
    e[6] = pk(2, 0, 0, 1, 0);    r[6] = 2'b01;
    e[7] = pk(2, 100, 0, 1, 0);  r[7] = 2'b01;
    for (int i = 0; i < 8; i++) begin
      bus.railed_in = r[i];
      step();
      total++;
      if (obs() !== e[i]) begin
        bad++; $display("FAIL dir_flip[%0d] got=%h exp=%h", i, obs(), e[i]);
      end
    end
    total++;
    if (bus.relock_count_out !== 16'd2) begin
      bad++; $display("FAIL dir_flip_relock got=%0d exp=2", bus.relock_count_out);
    end
    bus.enable_in = 1'b0;
    bus.railed_in = 2'b00;
    step();
    bus.enable_in = 1'b1;
  endtask

  task automatic test_zero_params();
    logic [21:0] e [4];
    logic [1:0]  r [4];
    e[0] = pk(1, 0, 1, 1, 0); r[0] = 2'b10;
    e[1] = pk(2, 0, 0, 1, 0); r[1] = 2'b00;
    e[2] = pk(3, 0, 0, 0, 0); r[2] = 2'b00;
    e[3] = pk(0, 0, 0, 0, 0); r[3] = 2'b00;
    bus.dwell_in  = 16'd0;
    bus.settle_in = 16'd0;
    for (int i = 0; i < 4; i++) begin
      bus.railed_in = r[i];
      step();
      total++;
      if (obs() !== e[i]) begin
        bad++; $display("FAIL zero_params[%0d] got=%h exp=%h", i, obs(), e[i]);
      end
    end
    bus.railed_in = 2'b11;
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (obs() !== pk(0, 0, 0, 0, 0)) begin
        bad++; $display("FAIL code11[%0d] got=%h exp=%h", i, obs(), pk(0, 0, 0, 0, 0));
      end
    end
    total++;
    if (bus.relock_count_out !== 16'd3) begin
      bad++; $display("FAIL zero_params_relock got=%0d exp=3", bus.relock_count_out);
    end
  endtask

  initial begin
    test_reset();
    test_dwell_short();
    test_ramp_high();
    test_settle_retry();
    test_reset_mid_ramp();
    test_saturation();
    test_dir_flip();
    test_zero_params();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
